// File: rtl/aes_pkg.sv
// Shared AES constants, key-schedule FSM states and small GF(2^8)/word helpers.
package aes_pkg;

  localparam int         AES_NUM_RK = 11;
  localparam logic [7:0] RCON_INIT  = 8'h01;
  localparam logic [7:0] XTIME_POLY = 8'h1b;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    EXPAND
  } ks_state_t;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? XTIME_POLY : 8'h00);
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box, purely combinational: GF(2^8) inverse (a^254) followed by the affine map.
// Zero latency, no handshake; shared with the round datapath.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  logic [7:0] x2, x3, x6, x7, x14, x15, x30, x31, x62, x63, x126, x127, inv;

  // a^254 is the multiplicative inverse, and maps 0 to 0 as the S-box requires
  always_comb begin
    x2       = gf_mul(in_byte, in_byte);
    x3       = gf_mul(x2, in_byte);
    x6       = gf_mul(x3, x3);
    x7       = gf_mul(x6, in_byte);
    x14      = gf_mul(x7, x7);
    x15      = gf_mul(x14, in_byte);
    x30      = gf_mul(x15, x15);
    x31      = gf_mul(x30, in_byte);
    x62      = gf_mul(x31, x31);
    x63      = gf_mul(x62, in_byte);
    x126     = gf_mul(x63, x63);
    x127     = gf_mul(x126, in_byte);
    inv      = gf_mul(x127, x127);
    out_byte = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
             ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end

endmodule

// File: rtl/aes_key_sched.sv
// AES-128 round-key generator: key accept -> idx0 in 1 cycle, then one round key per accepted beat; rk_data/rk_idx hold while rk_ready is low.
// Optional AES_KEY_SCHED_REVERSE_EN: with reverse=1 the keys are expanded into a store first (rk_valid=0), then emitted idx 10 down to 0.
module aes_key_sched
  import aes_pkg::*;
#(
  parameter int NUM_RK = AES_NUM_RK,
  parameter int KEY_W  = 128
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_valid,
  output logic             key_ready,
  input  logic [KEY_W-1:0] key_data,
  output logic             rk_valid,
  input  logic             rk_ready,
  output logic [KEY_W-1:0] rk_data,
  output logic [3:0]       rk_idx,
  output logic             done,
  input  logic             reverse
);

  localparam logic [3:0] LAST_IDX = 4'(NUM_RK - 1);

  ks_state_t        state_q, state_d;
  logic [KEY_W-1:0] rk_data_q, rk_data_d;
  logic [3:0]       rk_idx_q, rk_idx_d;
  logic [7:0]       rcon_q, rcon_d;
  logic             done_q, done_d;
  logic             last_key;

  logic [31:0]      w0, w1, w2, w3, rot_w3, sub_w, t_w, n0, n1, n2, n3;
  logic [KEY_W-1:0] next_key;

  assign {w0, w1, w2, w3} = rk_data_q;
  assign rot_w3 = rot_word(w3);

  for (genvar g = 0; g < 4; g++) begin : g_subword
    aes_sbox u_sbox (
      .in_byte  (rot_w3[8*g +: 8]),
      .out_byte (sub_w[8*g +: 8])
    );
  end

  assign t_w      = sub_w ^ {rcon_q, 24'h000000};
  assign n0       = w0 ^ t_w;
  assign n1       = w1 ^ n0;
  assign n2       = w2 ^ n1;
  assign n3       = w3 ^ n2;
  assign next_key = {n0, n1, n2, n3};

`ifdef AES_KEY_SCHED_REVERSE_EN
  logic             rev_q, rev_d;
  logic [KEY_W-1:0] store_q [NUM_RK];
  logic [KEY_W-1:0] store_d [NUM_RK];

  assign last_key = rev_q ? (rk_idx_q == 4'd0) : (rk_idx_q == LAST_IDX);

  // key store is pure datapath; its contents only matter after EXPAND fills it
  always_ff @(posedge clk) begin
    store_q <= store_d;
  end
`else
  logic unused_reverse;
  assign unused_reverse = reverse;
  assign last_key       = (rk_idx_q == LAST_IDX);
`endif

  always_comb begin
    state_d   = state_q;
    rk_data_d = rk_data_q;
    rk_idx_d  = rk_idx_q;
    rcon_d    = rcon_q;
    done_d    = 1'b0;
`ifdef AES_KEY_SCHED_REVERSE_EN
    rev_d     = rev_q;
    store_d   = store_q;
`endif
    case (state_q)
      IDLE: begin
        if (key_valid) begin
          rk_data_d = key_data;
          rk_idx_d  = 4'd0;
          rcon_d    = RCON_INIT;
          state_d   = RUN;
`ifdef AES_KEY_SCHED_REVERSE_EN
          rev_d      = reverse;
          store_d[0] = key_data;
          if (reverse) state_d = EXPAND;
`endif
        end
      end
      RUN: begin
        if (rk_ready) begin
          if (last_key) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
`ifdef AES_KEY_SCHED_REVERSE_EN
          else if (rev_q) begin
            rk_data_d = store_q[rk_idx_q - 4'd1];
            rk_idx_d  = rk_idx_q - 4'd1;
          end
`endif
          else begin
            rk_data_d = next_key;
            rk_idx_d  = rk_idx_q + 4'd1;
            rcon_d    = xtime(rcon_q);
          end
        end
      end
`ifdef AES_KEY_SCHED_REVERSE_EN
      // leaves with rk_data = round key 10, ready to walk the store downwards
      EXPAND: begin
        store_d[rk_idx_q + 4'd1] = next_key;
        rk_data_d = next_key;
        rk_idx_d  = rk_idx_q + 4'd1;
        rcon_d    = xtime(rcon_q);
        if (rk_idx_q == LAST_IDX - 4'd1) state_d = RUN;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rk_data_q <= '0;
      rk_idx_q  <= 4'd0;
      rcon_q    <= RCON_INIT;
      done_q    <= 1'b0;
`ifdef AES_KEY_SCHED_REVERSE_EN
      rev_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      rk_data_q <= rk_data_d;
      rk_idx_q  <= rk_idx_d;
      rcon_q    <= rcon_d;
      done_q    <= done_d;
`ifdef AES_KEY_SCHED_REVERSE_EN
      rev_q     <= rev_d;
`endif
    end
  end

  assign key_ready = (state_q == IDLE);
  assign rk_valid  = (state_q == RUN);
  assign rk_data   = rk_data_q;
  assign rk_idx    = rk_idx_q;
  assign done      = done_q;

endmodule
